fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: PC and PC+4 width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: predicted-target width.
REQ-003 SHALL have parameter INSTR_WIDTH, default 32: instruction width.
REQ-004 SHALL have parameter DEPTH, default 4: entry count; power of two, DEPTH >= 2.
REQ-005 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port i_arst_n  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have port i_flush  in  1  discard all entries (decode flush).
REQ-008 SHALL have port i_valid  in  1  fetch presents an entry.
REQ-009 SHALL have port o_ready  out  1  queue accepts an entry this cycle.
REQ-010 SHALL have ports i_branch_pred_taken 1, i_btb_way 2, i_pc_target_pred ADDR_WIDTH, i_instr INSTR_WIDTH, i_pc DATA_WIDTH, i_pc_plus4 DATA_WIDTH, all in: entry payload.
REQ-011 SHALL have port o_valid  out  1  head entry presented to decode.
REQ-012 SHALL have port i_ready  in  1  decode consumes head (i.e. not stalled).
REQ-013 SHALL have ports o_branch_pred_taken, o_btb_way, o_pc_target_pred, o_instr, o_pc, o_pc_plus4, all out, widths as REQ-010: head payload.
REQ-014 SHALL have port o_count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Push SHALL occur when i_valid & o_ready & ~i_flush; pop SHALL occur when o_valid & i_ready & ~i_flush.
REQ-016 o_ready SHALL equal (o_count != DEPTH); no combinational dependence on i_ready.
REQ-017 o_valid SHALL equal (o_count != 0).
REQ-018 Entries SHALL leave in push order (FIFO); head payload is driven from storage, combinational from head pointer only.
REQ-019 Payload outputs SHALL be all-zero whenever o_valid=0 (bubble, matching a flushed pipeline register).
REQ-020 Latency: an entry pushed into an empty queue in cycle N SHALL appear with o_valid=1 in cycle N+1; no same-cycle bypass.
REQ-021 Simultaneous push and pop SHALL leave o_count unchanged, advance both pointers; legal at any non-empty, non-full occupancy.
REQ-022 When full, pop SHALL free a slot visible as o_ready=1 the next cycle; a same-cycle push is refused.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 o_count SHALL increment on push-only, decrement on pop-only, never exceed DEPTH nor underflow.
REQ-025 i_flush SHALL take priority over push and pop: next cycle o_count=0, pointers=0, o_valid=0, o_ready=1.
REQ-026 Storage contents need not be cleared on flush; only pointers/count reset.

Reset
REQ-027 On i_arst_n=0, asynchronously: pointers=0, o_count=0, o_valid=0, o_ready=1, all payload outputs 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-029 Storage array SHALL NOT require reset.

Structure
REQ-030 Package fetch_pkg SHALL hold typedef fetch_entry_t (packed struct of the six payload fields) and BTB_WAY_WIDTH=2.
REQ-031 One sub-module SHALL be used: fq_ptr, a parametrised wrapping pointer with increment and clear, instantiated for read and write pointers.
REQ-032 Storage SHALL be a DEPTH-entry array of fetch_entry_t in flip-flops.

Verification
REQ-033 Reset release, no traffic -> o_valid=0, o_ready=1, o_count=0, payload 0.
REQ-034 Push pc=0x1000,0x1004,0x1008,0x100C with i_ready=0 -> o_count=4, o_ready=0; 5th push refused; then i_ready=1 -> pops 0x1000..0x100C in order.
REQ-035 Empty queue, push pc=0x2000 cycle N -> o_valid=1, o_pc=0x2000 at N+1, not at N.
REQ-036 o_count=2, push+pop same cycle for 8 cycles -> o_count stays 2, pointers wrap, order preserved.
REQ-037 o_count=3, i_flush=1 with i_valid=1 and i_ready=1 -> next cycle o_count=0, o_valid=0, payload 0, pushed entry lost.
REQ-038 o_count=2, i_arst_n pulsed low between edges -> o_valid=0, o_count=0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: the payload record and its field widths.
package fetch_pkg;

  localparam int BTB_WAY_WIDTH   = 2;
  localparam int FQ_PC_WIDTH     = 64;
  localparam int FQ_TARGET_WIDTH = 64;
  localparam int FQ_INSTR_WIDTH  = 32;

  // One fetched instruction plus its prediction metadata, as handed to decode.
  // Field widths are the widest the queue supports; narrower instances
  // zero-extend on the way in and truncate on the way out.
  typedef struct packed {
    logic                       branch_pred_taken;
    logic [BTB_WAY_WIDTH-1:0]   btb_way;
    logic [FQ_TARGET_WIDTH-1:0] pc_target_pred;
    logic [FQ_INSTR_WIDTH-1:0]  instr;
    logic [FQ_PC_WIDTH-1:0]     pc;
    logic [FQ_PC_WIDTH-1:0]     pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping index into a power-of-two ring buffer, with increment and clear.
module fq_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_clr,
  input  logic                     i_inc,
  output logic [$clog2(DEPTH)-1:0] o_ptr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Clear wins over increment; the last slot wraps back to zero.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO: DEPTH entries of fetch payload, no same-cycle bypass,
// flush discards everything, payload outputs read zero when empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic                      i_flush,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_branch_pred_taken,
  input  logic [BTB_WAY_WIDTH-1:0]  i_btb_way,
  input  logic [ADDR_WIDTH-1:0]     i_pc_target_pred,
  input  logic [INSTR_WIDTH-1:0]    i_instr,
  input  logic [DATA_WIDTH-1:0]     i_pc,
  input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_branch_pred_taken,
  output logic [BTB_WAY_WIDTH-1:0]  o_btb_way,
  output logic [ADDR_WIDTH-1:0]     o_pc_target_pred,
  output logic [INSTR_WIDTH-1:0]    o_instr,
  output logic [DATA_WIDTH-1:0]     o_pc,
  output logic [DATA_WIDTH-1:0]     o_pc_plus4,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  wrEntry;
  fetch_entry_t  headEntry;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          doPush;
  logic          doPop;

  // Status comes only from the occupancy register, so ready never depends
  // combinationally on the decode side.
  assign o_valid = (count_q != '0);
  assign o_ready = (count_q != CW'(DEPTH));

  assign doPush = i_valid & o_ready & ~i_flush;
  assign doPop  = o_valid & i_ready & ~i_flush;

  fq_ptr #(.DEPTH(DEPTH)) uWrPtr (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clr    (i_flush),
    .i_inc    (doPush),
    .o_ptr    (wrPtr)
  );

  fq_ptr #(.DEPTH(DEPTH)) uRdPtr (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clr    (i_flush),
    .i_inc    (doPop),
    .o_ptr    (rdPtr)
  );

  // Pack the incoming payload into the stored record.
  always_comb begin
    wrEntry                   = '0;
    wrEntry.branch_pred_taken = i_branch_pred_taken;
    wrEntry.btb_way           = i_btb_way;
    wrEntry.pc_target_pred    = FQ_TARGET_WIDTH'(i_pc_target_pred);
    wrEntry.instr             = FQ_INSTR_WIDTH'(i_instr);
    wrEntry.pc                = FQ_PC_WIDTH'(i_pc);
    wrEntry.pc_plus4          = FQ_PC_WIDTH'(i_pc_plus4);
  end

  // Occupancy: flush empties, push-only grows, pop-only shrinks, both holds.
  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else begin
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register; reset empties the queue without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (doPush) begin
      mem_q[wrPtr] <= wrEntry;
    end
  end

  // Head is read straight from storage and forced to a zero bubble when empty.
  always_comb begin
    headEntry = '0;
    if (o_valid) begin
      headEntry = mem_q[rdPtr];
    end
  end

  assign o_branch_pred_taken = headEntry.branch_pred_taken;
  assign o_btb_way           = headEntry.btb_way;
  assign o_pc_target_pred    = ADDR_WIDTH'(headEntry.pc_target_pred);
  assign o_instr             = INSTR_WIDTH'(headEntry.instr);
  assign o_pc                = DATA_WIDTH'(headEntry.pc);
  assign o_pc_plus4          = DATA_WIDTH'(headEntry.pc_plus4);
  assign o_count             = count_q;

endmodule
